// File: rtl/stack_pkg.sv
// Shared types and constants for the return-address stack.
package stack_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH_PEND = 2'd1,
        POP_PEND  = 2'd2
    } state_e;

    // SP after reset is one past the deepest entry, which is the empty marker.
    function automatic int unsigned sp_reset_val(input int unsigned depth);
        return depth;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one combinational read port.
module stack_ram
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Return-address stack with SP register and one-deep pending-op tracker.
// Full/empty guards and sticky flags are built only with STACK_GUARD_EN.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned SP_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sp_load_en,
    input  logic [DATA_W-1:0] sp_load_val,
    input  logic              dcr_sp,
    input  logic              spr,
    input  logic              spw,
    input  logic              inr_sp,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [SP_W-1:0]   sp,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned     AW     = SP_W - 1;
    localparam logic [SP_W-1:0] SP_RST = SP_W'(sp_reset_val(DEPTH));

    state_e            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              blk_q, blk_d;

    logic [SP_W-1:0]   sp_res_c;
    logic              we_c;
    logic              full_c;
    logic              empty_c;
    logic [DATA_W-1:0] ram_rd_c;
    logic              unused_load_bits;

    assign unused_load_bits = ^sp_load_val[DATA_W-1:SP_W];

    // Decrement wraps from 0 to the top entry (reachable only without guards).
    function automatic logic [SP_W-1:0] sp_dec(input logic [SP_W-1:0] s);
        return (s == '0) ? SP_W'(DEPTH - 1) : s - SP_W'(1);
    endfunction

    // Increment past empty wraps within the low address bits.
    function automatic logic [SP_W-1:0] sp_inc(input logic [SP_W-1:0] s);
        return (s >= SP_RST) ? {1'b0, s[AW-1:0] + AW'(1)} : s + SP_W'(1);
    endfunction

    stack_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we_c),
        .waddr   (sp_q[AW-1:0]),
        .wdata   (wdata),
        .raddr   (sp_res_c[AW-1:0]),
        .rdata_c (ram_rd_c)
    );

    // Stage-2 resolution of the pending op; yields the SP seen by stage 1.
    always_comb begin
        we_c     = 1'b0;
        sp_res_c = sp_q;
        unique case (state_q)
            PUSH_PEND: begin
                if (!blk_q) begin
                    if (spw) begin
                        we_c = 1'b1;
                    end else begin
                        sp_res_c = sp_inc(sp_q);
                    end
                end
            end
            POP_PEND: begin
                if (!blk_q && inr_sp) begin
                    sp_res_c = sp_inc(sp_q);
                end
            end
            default: ;
        endcase
    end

`ifdef STACK_GUARD_EN
    assign full_c  = (sp_res_c == '0);
    assign empty_c = (sp_res_c == SP_RST);
`else
    assign full_c  = 1'b0;
    assign empty_c = 1'b0;
`endif

    // Stage-1 op on the resolved SP, then SP load override.
    always_comb begin
        state_d = IDLE;
        sp_d    = sp_res_c;
        rdata_d = rdata_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        blk_d   = 1'b0;

        if (dcr_sp) begin
            state_d = PUSH_PEND;
            if (full_c) begin
                ovf_d = 1'b1;
                blk_d = 1'b1;
            end else begin
                sp_d = sp_dec(sp_res_c);
            end
        end else if (spr) begin
            state_d = POP_PEND;
            if (empty_c) begin
                unf_d   = 1'b1;
                blk_d   = 1'b1;
                rdata_d = '0;
            end else begin
                // A commit this cycle writes exactly the entry being read.
                rdata_d = we_c ? wdata : ram_rd_c;
            end
        end

        if (sp_load_en) begin
            sp_d    = sp_load_val[SP_W-1:0];
            state_d = IDLE;
            blk_d   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= SP_RST;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            blk_q   <= blk_d;
        end
    end

    assign rdata     = rdata_q;
    assign sp        = sp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
